// File: rtl/hires_pkg.sv
// Shared Apple II HIRES geometry constants and row address helper.
package hires_pkg;

    localparam int unsigned HIRES_ROWS  = 192;
    localparam int unsigned HIRES_COLS  = 40;
    localparam logic [15:0] HIRES_PAGE1 = 16'h2000;
    localparam logic [15:0] HIRES_PAGE2 = 16'h4000;

    typedef enum logic [1:0] {StIdle, StRun, StDone} row_state_e;

    // Page-relative base of a screen row: the 3-level HIRES interleave.
    // row[7:6]*40 is formed as *32 + *8 to stay in plain adds.
    function automatic logic [15:0] hires_row_addr(input logic [7:0] row);
        logic [15:0] a;
        a = {3'b0, row[2:0], 10'b0}
          + {6'b0, row[5:3], 7'b0}
          + {9'b0, row[7:6], 5'b0}
          + {11'b0, row[7:6], 3'b0};
        return a;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a preview of the head entry as it will be after this cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 7,
    parameter int unsigned DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head_next,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW-1:0]    rd_ptr_inc;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_after_pop;
    logic             do_push;
    logic             do_pop;

    // Flags, qualified push/pop, and the head value visible next cycle.
    always_comb begin
        empty         = (cnt_q == '0);
        full          = (cnt_q == CW'(DEPTH));
        do_pop        = pop && !empty;
        // A push into a full FIFO is fine when a pop frees a slot in the same cycle.
        do_push       = push && (!full || do_pop);
        rd_ptr_inc    = rd_ptr_q + 1'b1;
        cnt_after_pop = cnt_q - CW'(do_pop);
        count         = cnt_q;
        // When the FIFO drains this cycle the incoming byte becomes the new head.
        if (cnt_after_pop == '0) begin
            head_next = wdata;
        end else if (do_pop) begin
            head_next = mem_q[rd_ptr_inc];
        end else begin
            head_next = mem_q[rd_ptr_q];
        end
    end

    // Storage array, no reset needed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_inc;
            end
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/hires_row_writer.sv
// Writes one HIRES screen row span to memory through a req/ack port, buffering bytes in a FIFO.
module hires_row_writer
    import hires_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [15:0] BASE_ADDR  = HIRES_PAGE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  row_sel,
    input  logic [5:0]  start_col,
    input  logic [5:0]  num_bytes,
    input  logic        palette,
    input  logic [6:0]  byte_in,
    input  logic        byte_valid,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_req,
    input  logic        mem_ack,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic        cfg_err
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    row_state_e  state_q;
    logic [15:0] addr_q;
    logic [5:0]  in_cnt_q;
    logic [5:0]  wr_cnt_q;
    logic        palette_q;
    logic        mem_req_q;
    logic [7:0]  mem_wdata_q;
    logic        busy_q;
    logic        done_q;
    logic        overflow_q;
    logic        cfg_err_q;

    logic          cfg_ok;
    logic          pop;
    logic          byte_take;
    logic          push;
    logic          drop;
    logic [5:0]    in_cnt_d;
    logic [5:0]    wr_cnt_d;
    logic [CW-1:0] fifo_cnt_next;
    logic          finish;
    logic          req_next;

    logic [6:0]    fifo_head_next;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;

    sync_fifo #(
        .WIDTH (7),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .wdata     (byte_in),
        .pop       (pop),
        .head_next (fifo_head_next),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Config check, FIFO traffic and the counter values after this cycle.
    always_comb begin
        cfg_ok = (row_sel < 8'(HIRES_ROWS)) && (num_bytes != '0)
              && (({1'b0, start_col} + {1'b0, num_bytes}) <= 7'(HIRES_COLS));
        // The FIFO head stays in place until its write is acked.
        pop           = mem_req_q && mem_ack && !fifo_empty;
        byte_take     = (state_q == StRun) && byte_valid && (in_cnt_q != '0);
        push          = byte_take && (!fifo_full || pop);
        drop          = byte_take && fifo_full && !pop;
        in_cnt_d      = in_cnt_q - 6'(byte_take);
        wr_cnt_d      = wr_cnt_q - 6'(pop);
        fifo_cnt_next = fifo_count + CW'(push) - CW'(pop);
        // Dropped bytes never arrive, so an exhausted input with a drained FIFO also ends the row.
        finish        = (wr_cnt_d == '0) || ((in_cnt_d == '0) && (fifo_cnt_next == '0));
        req_next      = !finish && (fifo_cnt_next != '0);
    end

    // Row FSM with registered request/status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            in_cnt_q    <= '0;
            wr_cnt_q    <= '0;
            palette_q   <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    done_q    <= 1'b0;
                    mem_req_q <= 1'b0;
                    if (start) begin
                        palette_q  <= palette;
                        addr_q     <= BASE_ADDR + hires_row_addr(row_sel) + {10'b0, start_col};
                        overflow_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= StRun;
                        // A bad config runs as a zero-length row: busy for one cycle,
                        // then done, with no bytes accepted and no writes issued.
                        if (cfg_ok) begin
                            in_cnt_q  <= num_bytes;
                            wr_cnt_q  <= num_bytes;
                            cfg_err_q <= 1'b0;
                        end else begin
                            in_cnt_q  <= '0;
                            wr_cnt_q  <= '0;
                            cfg_err_q <= 1'b1;
                        end
                    end
                end
                StRun: begin
                    in_cnt_q    <= in_cnt_d;
                    wr_cnt_q    <= wr_cnt_d;
                    mem_req_q   <= req_next;
                    mem_wdata_q <= {palette_q, fifo_head_next};
                    if (pop) begin
                        addr_q <= addr_q + 16'd1;
                    end
                    if (drop) begin
                        overflow_q <= 1'b1;
                    end
                    if (finish) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_req   = mem_req_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign overflow  = overflow_q;
    assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_hires_row_writer.sv
// Scoreboard bench for hires_row_writer: stimulus queues expected writes, a monitor checks them.
module tb_hires_row_writer;

    localparam int unsigned DEPTH = 8;
    localparam logic [15:0] BASE  = 16'h2000;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  row_sel;
    logic [5:0]  start_col;
    logic [5:0]  num_bytes;
    logic        palette;
    logic [6:0]  byte_in;
    logic        byte_valid;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_req;
    logic        mem_ack;
    logic        busy;
    logic        done;
    logic        overflow;
    logic        cfg_err;

    int checks = 0;
    int errors = 0;
    int n_writes = 0;
    int done_cnt = 0;
    int req_cycles = 0;
    int ack_mode = 0;      // 0 low, 1 high, 2 random
    int row_done0 = 0;
    int row_w0 = 0;
    logic [15:0] cur_addr;
    logic        cur_pal;
    logic [23:0] exp_q[$];

    hires_row_writer #(
        .FIFO_DEPTH (DEPTH),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .row_sel    (row_sel),
        .start_col  (start_col),
        .num_bytes  (num_bytes),
        .palette    (palette),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_req    (mem_req),
        .mem_ack    (mem_ack),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow),
        .cfg_err    (cfg_err)
    );

    always #5 clk = ~clk;

    // Apple II HIRES screen address, straight from the row/col arithmetic.
    function automatic logic [15:0] ref_addr(input int row, input int col);
        int a;
        a = int'(BASE) + (row % 8) * 1024 + ((row / 8) % 8) * 128 + (row / 64) * 40 + col;
        return a[15:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Memory acknowledge driver.
    initial begin
        mem_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ack_mode)
                0:       mem_ack = 1'b0;
                1:       mem_ack = 1'b1;
                default: mem_ack = ($urandom_range(0, 2) != 0);
            endcase
        end
    end

    // Monitor: every accepted write is matched against the scoreboard head.
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_req) req_cycles++;
            if (done) done_cnt++;
            if (mem_req && mem_ack) begin
                n_writes++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr %0h data %0h expected none",
                             mem_addr, mem_wdata);
                end else begin
                    logic [23:0] e;
                    e = exp_q.pop_front();
                    check("wr_addr", 32'(mem_addr), 32'(e[23:8]));
                    check("wr_data", 32'(mem_wdata), 32'(e[7:0]));
                end
            end
        end
    end

    task automatic start_row(input int row, input int col, input int n, input logic pal);
        cur_addr  = ref_addr(row, col);
        cur_pal   = pal;
        row_done0 = done_cnt;
        row_w0    = n_writes;
        row_sel   = 8'(row);
        start_col = 6'(col);
        num_bytes = 6'(n);
        palette   = pal;
        start     = 1'b1;
        cyc();
        start     = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic send_byte(input logic [6:0] b, input bit expect_wr);
        byte_in    = b;
        byte_valid = 1'b1;
        if (expect_wr) begin
            exp_q.push_back({cur_addr, cur_pal, b});
            cur_addr = cur_addr + 16'd1;
        end
        cyc();
        byte_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int t;
        t = 0;
        while (done_cnt == row_done0 && t < budget) begin
            cyc();
            t++;
        end
        cyc();
        cyc();
        check("done_pulses", 32'(done_cnt - row_done0), 32'd1);
        check("busy_after_done", 32'(busy), 32'd0);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; row_sel = '0; start_col = '0; num_bytes = '0;
        palette = 1'b0; byte_in = '0; byte_valid = 1'b0;
        repeat (3) cyc();
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_cfg_err", 32'(cfg_err), 32'd0);
        rst = 1'b0;
        cyc();

        // Full-width row at sustained throughput.
        ack_mode = 1;
        start_row(0, 0, 40, 1'b0);
        for (int i = 1; i <= 40; i++) send_byte(7'(i), 1'b1);
        wait_done(100);
        check("t1_writes", 32'(n_writes - row_w0), 32'd40);
        check("t1_overflow", 32'(overflow), 32'd0);

        // Interleaved row with palette bit set.
        start_row(65, 5, 3, 1'b1);
        for (int i = 0; i < 3; i++) send_byte(7'($urandom_range(0, 127)), 1'b1);
        wait_done(50);
        check("t2_writes", 32'(n_writes - row_w0), 32'd3);

        // Memory stalled: only the FIFO's worth of bytes survives.
        ack_mode = 0;
        start_row(17, 20, 12, 1'b0);
        for (int i = 0; i < 12; i++) send_byte(7'($urandom_range(0, 127)), i < int'(DEPTH));
        repeat (8) cyc();
        check("t3_overflow", 32'(overflow), 32'd1);
        check("t3_stalled_writes", 32'(n_writes - row_w0), 32'd0);
        check("t3_req_held", 32'(mem_req), 32'd1);
        ack_mode = 1;
        wait_done(50);
        check("t3_writes", 32'(n_writes - row_w0), 32'(DEPTH));

        // Excess bytes beyond num_bytes are ignored without overflow.
        start_row(100, 36, 4, 1'b0);
        check("t4_overflow_cleared", 32'(overflow), 32'd0);
        for (int i = 0; i < 6; i++) send_byte(7'(i + 9), i < 4);
        wait_done(50);
        check("t4_writes", 32'(n_writes - row_w0), 32'd4);
        check("t4_overflow", 32'(overflow), 32'd0);

        // Illegal configurations: row out of range, zero bytes, span past column 39.
        for (int k = 0; k < 3; k++) begin
            int r0;
            r0 = req_cycles;
            case (k)
                0:       start_row(192, 0, 1, 1'b0);
                1:       start_row(10, 0, 0, 1'b0);
                default: start_row(10, 39, 2, 1'b0);
            endcase
            check("cfg_err_set", 32'(cfg_err), 32'd1);
            check("cfg_done_not_yet", 32'(done), 32'd0);
            cyc();
            check("cfg_done_pulse", 32'(done), 32'd1);
            check("cfg_busy_low", 32'(busy), 32'd0);
            cyc();
            cyc();
            check("cfg_no_req", 32'(req_cycles - r0), 32'd0);
        end

        // Random rows, random ack pattern, throttled to stay below FIFO capacity.
        ack_mode = 2;
        for (int r = 0; r < 25; r++) begin
            int row, col, n, sent, guard;
            row = $urandom_range(0, 191);
            col = $urandom_range(0, 39);
            n   = $urandom_range(1, 40 - col);
            start_row(row, col, n, 1'($urandom_range(0, 1)));
            sent = 0;
            for (int i = 0; i < n; i++) begin
                repeat ($urandom_range(0, 2)) cyc();
                guard = 0;
                while ((sent - (n_writes - row_w0)) >= int'(DEPTH) - 1 && guard < 200) begin
                    cyc();
                    guard++;
                end
                send_byte(7'($urandom_range(0, 127)), 1'b1);
                sent++;
            end
            wait_done(400);
            check("rand_writes", 32'(n_writes - row_w0), 32'(n));
            check("rand_overflow", 32'(overflow), 32'd0);
        end

        // Reset while a request is pending, then a corner-cell row.
        ack_mode = 0;
        start_row(100, 10, 5, 1'b0);
        for (int i = 0; i < 3; i++) send_byte(7'(i + 1), 1'b0);
        cyc();
        check("t6_req_pending", 32'(mem_req), 32'd1);
        rst = 1'b1;
        cyc();
        check("t6_rst_req", 32'(mem_req), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        ack_mode = 1;
        cyc();
        start_row(191, 39, 1, 1'b1);
        check("t6_cfg_ok", 32'(cfg_err), 32'd0);
        send_byte(7'h55, 1'b1);
        wait_done(50);
        check("t6_writes", 32'(n_writes - row_w0), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
